// File: rtl/reg_file_4x8.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_4x8
// Purpose  : Four 8-bit registers with one write port and two registered
//            read ports. Reads are write-first: a read of the index being
//            written on the same edge returns the new data. A synchronous
//            clear zeroes every register and wins over a concurrent write.
// Ports    : clk        - single clock, rising-edge active
//            reset      - asynchronous active-high reset
//            wr_en      - write request
//            wr_addr    - write register index (2 bits)
//            wr_data    - write data (8 bits)
//            rd_en      - read request for both ports
//            rd_addr_a  - port A register index
//            rd_addr_b  - port B register index
//            clear      - synchronous clear of all registers
//            rd_data_a  - port A registered read data
//            rd_data_b  - port B registered read data
//            rd_valid   - one-cycle flag marking fresh read data
//            reg_out    - {r3,r2,r1,r0}, continuous view of the storage
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_4x8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int NREGS  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr_a,
    input  logic [ADDR_W-1:0]       rd_addr_b,
    input  logic                    clear,
    output logic [DATA_W-1:0]       rd_data_a,
    output logic [DATA_W-1:0]       rd_data_b,
    output logic                    rd_valid,
    output logic [NREGS*DATA_W-1:0] reg_out
);

    localparam logic [DATA_W-1:0] c_zero = '0;

    logic [DATA_W-1:0] r_mem [NREGS];
    logic [DATA_W-1:0] r_rd_data_a;
    logic [DATA_W-1:0] r_rd_data_b;
    logic              r_rd_valid;
    logic [DATA_W-1:0] w_rd_next_a;
    logic [DATA_W-1:0] w_rd_next_b;
    logic              w_wr_live;

    // A write only lands when clear is low; the bypass must see the same rule
    // so that a clear cycle never forwards the discarded write data.
    assign w_wr_live = wr_en & ~clear;

    // Next read data per port: clear forces zero, otherwise a same-index
    // write is forwarded, otherwise the stored value is returned.
    always_comb begin
        w_rd_next_a = r_mem[rd_addr_a];
        w_rd_next_b = r_mem[rd_addr_b];
        if (clear) begin
            w_rd_next_a = c_zero;
            w_rd_next_b = c_zero;
        end else begin
            if (w_wr_live && (wr_addr == rd_addr_a)) begin
                w_rd_next_a = wr_data;
            end
            if (w_wr_live && (wr_addr == rd_addr_b)) begin
                w_rd_next_b = wr_data;
            end
        end
    end

    // Storage: one register per index, each with its own decoded write enable.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_mem[gi] <= c_zero;
            end else if (clear) begin
                r_mem[gi] <= c_zero;
            end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                r_mem[gi] <= wr_data;
            end
        end
        assign reg_out[gi*DATA_W +: DATA_W] = r_mem[gi];
    end

    // Read pipeline: data holds while rd_en is low; valid tracks rd_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data_a <= c_zero;
            r_rd_data_b <= c_zero;
            r_rd_valid  <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data_a <= w_rd_next_a;
                r_rd_data_b <= w_rd_next_b;
            end
        end
    end

    assign rd_data_a = r_rd_data_a;
    assign rd_data_b = r_rd_data_b;
    assign rd_valid  = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_4x8.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_4x8
// Purpose  : Self-checking bench for reg_file_4x8 using a table of directed
//            vectors plus hand-written sequences for all-pairs reads and
//            mid-cycle reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_4x8;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        rd_en;
    logic [1:0]  rd_addr_a;
    logic [1:0]  rd_addr_b;
    logic        clear;
    logic [7:0]  rd_data_a;
    logic [7:0]  rd_data_b;
    logic        rd_valid;
    logic [31:0] reg_out;

    int checks;
    int failures;

    reg_file_4x8 dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .clear     (clear),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_valid  (rd_valid),
        .reg_out   (reg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  wa;
        logic [7:0]  wd;
        logic        re;
        logic [1:0]  ra;
        logic [1:0]  rb;
        logic        clr;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic        ev;
        logic [31:0] eo;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                         input logic re, input logic [1:0] ra, input logic [1:0] rb,
                         input logic clr);
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_en     = re;
        rd_addr_a = ra;
        rd_addr_b = rb;
        clear     = clr;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] model [4];

    initial begin
        checks   = 0;
        failures = 0;

        // we wa  wd     re ra rb clr  ea     eb     ev   eo
        vecs[0]  = '{1'b1, 2'd0, 8'hA5, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 32'h000000A5};
        vecs[1]  = '{1'b1, 2'd1, 8'h3C, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 32'h00003CA5};
        vecs[2]  = '{1'b1, 2'd2, 8'hF0, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 32'h00F03CA5};
        vecs[3]  = '{1'b1, 2'd3, 8'h0F, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 32'h0FF03CA5};
        vecs[4]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd3, 1'b0, 8'hA5, 8'h0F, 1'b1, 32'h0FF03CA5};
        // same-edge write to r2 with both ports reading r2: bypass
        vecs[5]  = '{1'b1, 2'd2, 8'h77, 1'b1, 2'd2, 2'd2, 1'b0, 8'h77, 8'h77, 1'b1, 32'h0F773CA5};
        // one-cycle read pulse, then three idle cycles hold the data
        vecs[6]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd0, 1'b0, 8'h3C, 8'hA5, 1'b1, 32'h0F773CA5};
        vecs[7]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 2'd3, 1'b0, 8'h3C, 8'hA5, 1'b0, 32'h0F773CA5};
        vecs[8]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 2'd2, 1'b0, 8'h3C, 8'hA5, 1'b0, 32'h0F773CA5};
        vecs[9]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 8'h3C, 8'hA5, 1'b0, 32'h0F773CA5};
        // bypass on port A only; port B reads stored r1
        vecs[10] = '{1'b1, 2'd3, 8'h5A, 1'b1, 2'd3, 2'd1, 1'b0, 8'h5A, 8'h3C, 1'b1, 32'h5A773CA5};
        // clear beats a same-cycle write and reads return zero
        vecs[11] = '{1'b1, 2'd1, 8'hFF, 1'b1, 2'd1, 2'd3, 1'b1, 8'h00, 8'h00, 1'b1, 32'h00000000};
        vecs[12] = '{1'b1, 2'd0, 8'h11, 1'b1, 2'd0, 2'd0, 1'b0, 8'h11, 8'h11, 1'b1, 32'h00000011};

        // ---------------- reset state ----------------
        reset = 1'b1;
        drive(1'b1, 2'd1, 8'hCC, 1'b1, 2'd1, 2'd1, 1'b0);
        #2;
        chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset_rd_data_a", {24'd0, rd_data_a}, 32'd0);
        chk("reset_rd_data_b", {24'd0, rd_data_b}, 32'd0);
        chk("reset_reg_out", reg_out, 32'd0);
        tick();
        tick();
        chk("reset_hold_reg_out", reg_out, 32'd0);
        chk("reset_hold_rd_valid", {31'd0, rd_valid}, 32'd0);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0);
        reset = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra, vecs[i].rb, vecs[i].clr);
            tick();
            chk($sformatf("vec%0d_rd_data_a", i), {24'd0, rd_data_a}, {24'd0, vecs[i].ea});
            chk($sformatf("vec%0d_rd_data_b", i), {24'd0, rd_data_b}, {24'd0, vecs[i].eb});
            chk($sformatf("vec%0d_rd_valid", i), {31'd0, rd_valid}, {31'd0, vecs[i].ev});
            chk($sformatf("vec%0d_reg_out", i), reg_out, vecs[i].eo);
        end

        // ---------------- all 16 address pairs ----------------
        model[0] = 8'hC1;
        model[1] = 8'h52;
        model[2] = 8'hE3;
        model[3] = 8'h94;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), model[i], 1'b0, 2'd0, 2'd0, 1'b0);
            tick();
        end
        chk("load_reg_out", reg_out, {model[3], model[2], model[1], model[0]});
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                drive(1'b0, 2'd0, 8'h00, 1'b1, 2'(a), 2'(b), 1'b0);
                tick();
                chk($sformatf("pair%0d%0d_a", a, b), {24'd0, rd_data_a}, {24'd0, model[a]});
                chk($sformatf("pair%0d%0d_b", a, b), {24'd0, rd_data_b}, {24'd0, model[b]});
                chk($sformatf("pair%0d%0d_valid", a, b), {31'd0, rd_valid}, 32'd1);
            end
        end

        // ---------------- reset between edges ----------------
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd3, 1'b0);
        tick();
        chk("pre_reset_rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("pre_reset_rd_data_a", {24'd0, rd_data_a}, {24'd0, model[2]});
        // still in the first half of the cycle; no edge before the checks
        drive(1'b1, 2'd2, 8'hEE, 1'b1, 2'd2, 2'd2, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("async_reset_rd_data_a", {24'd0, rd_data_a}, 32'd0);
        chk("async_reset_rd_data_b", {24'd0, rd_data_b}, 32'd0);
        chk("async_reset_reg_out", reg_out, 32'd0);
        tick();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0);
        #2;
        reset = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd1, 1'b0);
        tick();
        chk("post_reset_r0", {24'd0, rd_data_a}, 32'd0);
        chk("post_reset_r1", {24'd0, rd_data_b}, 32'd0);
        chk("post_reset_valid", {31'd0, rd_valid}, 32'd1);
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd3, 1'b0);
        tick();
        chk("post_reset_r2", {24'd0, rd_data_a}, 32'd0);
        chk("post_reset_r3", {24'd0, rd_data_b}, 32'd0);
        chk("post_reset_reg_out", reg_out, 32'd0);

        // first edge after reset accepts a write and a bypassed read
        drive(1'b1, 2'd3, 8'h6B, 1'b1, 2'd3, 2'd0, 1'b0);
        tick();
        chk("after_reset_write_a", {24'd0, rd_data_a}, 32'h6B);
        chk("after_reset_reg_out", reg_out, 32'h6B000000);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_4x8.md
REG_FILE_4X8 -- requirements
Module: reg_file_4x8

Interface
REQ-001 The block SHALL have the port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 The block SHALL have the port: reset  input  1  asynchronous, active-high reset.
REQ-003 The block SHALL have the port: wr_en  input  1  write request.
REQ-004 The block SHALL have the port: wr_addr  input  2  write register index.
REQ-005 The block SHALL have the port: wr_data  input  8  write data.
REQ-006 The block SHALL have the port: rd_en  input  1  read request, both ports.
REQ-007 The block SHALL have the port: rd_addr_a  input  2  port A register index; same encoding as a 2-bit mux select.
REQ-008 The block SHALL have the port: rd_addr_b  input  2  port B register index.
REQ-009 The block SHALL have the port: clear  input  1  synchronous clear of all registers.
REQ-010 The block SHALL have the port: rd_data_a  output  8  port A registered read data.
REQ-011 The block SHALL have the port: rd_data_b  output  8  port B registered read data.
REQ-012 The block SHALL have the port: rd_valid  output  1  high for one cycle when rd_data_a/b hold a fresh read.
REQ-013 The block SHALL have the port: reg_out  output  32  all four registers, concatenated as {r3,r2,r1,r0}; r0 in bits 7:0; feeds the downstream 4:1 select stage.

Function
REQ-014 The storage SHALL consist of four 8-bit registers, r0..r3.
REQ-015 A write SHALL take effect as follows: on a clk edge with wr_en=1 and clear=0, r[wr_addr] takes wr_data; other registers hold.
REQ-016 A read SHALL have a latency of one cycle: on a clk edge with rd_en=1, rd_data_a and rd_data_b load r[rd_addr_a] and r[rd_addr_b], and rd_valid goes 1 for the following cycle.
REQ-017 When rd_en=0 on a clk edge, rd_valid SHALL go 0 and rd_data_a/b SHALL hold their previous values.
REQ-018 A read and a write to the same index on the same edge SHALL be write-first: the read port returns wr_data, not the old contents. This applies to each port independently.
REQ-019 When both read ports address the same index, both SHALL return identical data, including the bypass case.
REQ-020 Clear SHALL work as follows: on a clk edge with clear=1, r0..r3 become 8'h00 and any write in that cycle is discarded.
REQ-021 A read in the same cycle as clear SHALL return 8'h00 with rd_valid=1.
REQ-022 reg_out SHALL be a continuous view of r0..r3 and SHALL reflect a write or clear in the cycle after the edge, with no extra delay.
REQ-023 The block SHALL contain no combinational path from any input to rd_data_a, rd_data_b, or rd_valid.
REQ-024 All addresses SHALL be fully decoded (4 of 4); no invalid index exists and no default or error branch is required.

Reset
REQ-025 While reset=1, regardless of clk, r0..r3 SHALL be 8'h00, rd_data_a and rd_data_b SHALL be 8'h00, rd_valid SHALL be 0, and reg_out SHALL be 32'h0.
REQ-026 Reset asserted mid-operation SHALL immediately abort a pending read (rd_valid drops to 0 asynchronously) and SHALL discard a same-cycle write.
REQ-027 After reset deasserts, the first clk edge SHALL accept writes and reads normally.

Verification
REQ-028 The bench SHALL cover: reset, then write r0=8'hA5, r1=8'h3C, r2=8'hF0, r3=8'h0F; then rd_en with a=0, b=3 -> next cycle rd_data_a=8'hA5, rd_data_b=8'h0F, rd_valid=1; reg_out=32'h0FF03CA5.
REQ-029 The bench SHALL cover: same-edge wr_en=1, wr_addr=2, wr_data=8'h77, and rd_en=1 with a=2, b=2 -> rd_data_a=rd_data_b=8'h77 (bypass).
REQ-030 The bench SHALL cover: rd_en pulsed for one cycle, then held 0 for three cycles -> rd_valid is high for exactly one cycle and rd_data_a/b hold their values.
REQ-031 The bench SHALL cover: clear=1 with wr_en=1, wr_addr=1, wr_data=8'hFF, and rd_en=1 with a=1 -> rd_data_a=8'h00 and reg_out=32'h0.
REQ-032 The bench SHALL cover: reset asserted between clk edges while rd_valid=1 -> rd_valid=0 and rd_data_a/b=8'h00 before the next edge, and all registers read back 8'h00 after reset deasserts.
REQ-033 The bench SHALL cover: all 16 (a,b) address pairs after loading distinct values -> every port returns its own register, checked against a reference model.
